// File: rtl/march_bist_engine.sv
// March C- BIST engine: drives the BIST side of the memory input mux and checks read data.
// Outputs are registered; read compare happens on the cycle after each read strobe.
module march_bist_engine #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  NbarT,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic [DATA_WIDTH-1:0] bist_wdata,
    output logic                  bist_we,
    output logic                  bist_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH+3:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH+3:0] ERR_MAX  = {(ADDR_WIDTH+4){1'b1}};

    state_t                  state, state_nxt;
    logic [2:0]              elem, elem_nxt;
    logic                    phase, phase_nxt;
    logic [ADDR_WIDTH-1:0]   op_addr, addr_nxt;
    logic                    we_nxt, re_nxt, exp_nxt, rd_exp, clr;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic                    two_op, down, last_addr;

    logic                    cmp_vld, cmp_exp, miscmp;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic [2:0]              cmp_elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        phase_nxt = phase;
        op_addr   = '0;
        addr_nxt  = '0;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        wdata_nxt = '0;
        exp_nxt   = 1'b0;
        clr       = 1'b0;
        // M1..M4 are read-then-write per address; M0 and M5 have a single op
        two_op    = (elem != 3'd0) && (elem != 3'd5);
        down      = (elem == 3'd3) || (elem == 3'd4);
        last_addr = down ? (bist_addr == '0) : (bist_addr == ADDR_MAX);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                    elem_nxt  = 3'd0;
                    phase_nxt = 1'b0;
                end
            end
            RUN: begin
                if (two_op && !phase) begin
                    phase_nxt = 1'b1;
                    op_addr   = bist_addr;
                end else if (!last_addr) begin
                    phase_nxt = 1'b0;
                    op_addr   = down ? bist_addr - ADDR_WIDTH'(1) : bist_addr + ADDR_WIDTH'(1);
                end else if (elem == 3'd5) begin
                    state_nxt = FLUSH;
                end else begin
                    // element boundary: M3/M4 start at the top, the rest at 0
                    phase_nxt = 1'b0;
                    elem_nxt  = elem + 3'd1;
                    op_addr   = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                end
            end
            FLUSH:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == RUN) begin
            addr_nxt = op_addr;
            if ((elem_nxt == 3'd5) || ((elem_nxt != 3'd0) && !phase_nxt)) begin
                re_nxt  = 1'b1;
                exp_nxt = (elem_nxt == 3'd2) || (elem_nxt == 3'd4);
            end else begin
                we_nxt    = 1'b1;
                wdata_nxt = {DATA_WIDTH{(elem_nxt == 3'd1) || (elem_nxt == 3'd3)}};
            end
        end
    end

    assign miscmp = cmp_vld && (mem_rdata != {DATA_WIDTH{cmp_exp}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            NbarT      <= 1'b0;
            done       <= 1'b0;
            bist_addr  <= '0;
            bist_wdata <= '0;
            bist_we    <= 1'b0;
            bist_re    <= 1'b0;
            elem       <= 3'd0;
            phase      <= 1'b0;
            rd_exp     <= 1'b0;
            cmp_vld    <= 1'b0;
            cmp_exp    <= 1'b0;
            cmp_addr   <= '0;
            cmp_elem   <= 3'd0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            err_cnt    <= '0;
        end else begin
            NbarT      <= (state_nxt == RUN) || (state_nxt == FLUSH);
            done       <= (state_nxt == DONE);
            bist_addr  <= addr_nxt;
            bist_wdata <= wdata_nxt;
            bist_we    <= we_nxt;
            bist_re    <= re_nxt;
            elem       <= elem_nxt;
            phase      <= phase_nxt;
            rd_exp     <= exp_nxt;
            cmp_vld    <= bist_re;
            cmp_exp    <= rd_exp;
            cmp_addr   <= bist_addr;
            cmp_elem   <= elem;
            if (clr) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= 3'd0;
                err_cnt   <= '0;
            end else if (miscmp) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
